fp_sub_seq: RTL

//  Multi-cycle IEEE-754 single-precision subtractor computing data1 - data2; the inverse op of the FPU adder.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fp_unpack.sv | 27 ++
 rtl/fp_sub_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU datapaths.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int MANT_W = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam logic [4:0]       MAX_ALIGN = 5'd25;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SUB   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } sub_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits a single-precision word into sign, exponent and 24-bit mantissa;
// a zero exponent field flushes the operand to zero.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]       i_op,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant
);

    fp32_t w_op;

    assign w_op = fp32_t'(i_op);

    // Field extraction with implicit leading one
    always_comb begin
        o_sign = w_op.sign;
        o_exp  = w_op.exp;
        if (w_op.exp != 8'd0) begin
            o_mant = {1'b1, w_op.frac};
        end else begin
            o_mant = {MANT_W{1'b0}};
        end
    end

endmodule

// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: data1 - data2, aligning and
// normalising one bit per cycle, valid/ready on both sides.
module fp_sub_seq
    import fpu_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    sub_state_t r_state;
    sub_state_t w_next;

    logic                     w_s1, w_s2;
    logic [EXP_W-1:0]         w_e1, w_e2, w_diff;
    logic [MANT_W-1:0]        w_m1, w_m2;
    logic [31:0]              w_data2_neg;
    logic                     w_swap;
    logic [4:0]               w_shift;
    logic                     w_a_ge_b, w_sub_sign, w_sub_zero;
    logic [MANT_W:0]          w_sub_mant;
    logic                     w_ovf, w_unf, w_norm_ok;

    logic                     r_sign_a, r_sign_b, r_sign;
    logic [MANT_W-1:0]        r_mant_a, r_mant_b;
    logic [MANT_W:0]          r_mant;
    logic signed [EXP_W+1:0]  r_exp;
    logic [4:0]               r_cnt;
    logic [31:0]              r_result;
    logic                     r_ovf, r_unf;

    // Subtraction is addition of the subtrahend with its sign flipped
    assign w_data2_neg = {~data2[31], data2[30:0]};

    fp_unpack u_unpack_1 (.i_op(data1),       .o_sign(w_s1), .o_exp(w_e1), .o_mant(w_m1));
    fp_unpack u_unpack_2 (.i_op(w_data2_neg), .o_sign(w_s2), .o_exp(w_e2), .o_mant(w_m2));

    // Operand ordering and capped alignment distance
    always_comb begin
        w_swap = (w_e2 > w_e1);
        if (w_swap) begin
            w_diff = w_e2 - w_e1;
        end else begin
            w_diff = w_e1 - w_e2;
        end
        if (w_diff > {3'b000, MAX_ALIGN}) begin
            w_shift = MAX_ALIGN;
        end else begin
            w_shift = w_diff[4:0];
        end
    end

    // Signed-magnitude add/subtract of the aligned mantissas
    always_comb begin
        w_a_ge_b = (r_mant_a >= r_mant_b);
        if (r_sign_a == r_sign_b) begin
            w_sub_mant = {1'b0, r_mant_a} + {1'b0, r_mant_b};
            w_sub_sign = r_sign_a;
        end else if (w_a_ge_b) begin
            w_sub_mant = {1'b0, r_mant_a} - {1'b0, r_mant_b};
            w_sub_sign = r_sign_a;
        end else begin
            w_sub_mant = {1'b0, r_mant_b} - {1'b0, r_mant_a};
            w_sub_sign = r_sign_b;
        end
        w_sub_zero = (w_sub_mant == {(MANT_W+1){1'b0}});
    end

    // Normalisation exit conditions
    always_comb begin
        w_ovf     = (r_exp >= 10'sd255);
        w_unf     = (r_exp <= 10'sd0);
        w_norm_ok = r_mant[MANT_W-1] && !r_mant[MANT_W];
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = (w_shift == 5'd0) ? SUB : ALIGN;
                     else          w_next = IDLE;
            ALIGN:   if (r_cnt == 5'd1) w_next = SUB;
                     else               w_next = ALIGN;
            SUB:     if (w_sub_zero) w_next = DONE;
                     else            w_next = NORM;
            NORM:    if (w_ovf || w_unf || w_norm_ok) w_next = DONE;
                     else                             w_next = NORM;
            DONE:    if (out_ready) w_next = IDLE;
                     else           w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath registers advanced by the current state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_sign   <= 1'b0;
            r_mant_a <= {MANT_W{1'b0}};
            r_mant_b <= {MANT_W{1'b0}};
            r_mant   <= {(MANT_W+1){1'b0}};
            r_exp    <= 10'sd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign_a <= w_swap ? w_s2 : w_s1;
                    r_mant_a <= w_swap ? w_m2 : w_m1;
                    r_sign_b <= w_swap ? w_s1 : w_s2;
                    r_mant_b <= w_swap ? w_m1 : w_m2;
                    r_exp    <= {2'b00, (w_swap ? w_e2 : w_e1)};
                    r_cnt    <= w_shift;
                end
                ALIGN: begin
                    r_mant_b <= r_mant_b >> 1;
                    r_cnt    <= r_cnt - 5'd1;
                end
                SUB: begin
                    r_mant <= w_sub_mant;
                    r_sign <= w_sub_sign;
                    if (w_sub_zero) begin
                        r_result <= 32'd0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                    end
                end
                NORM: begin
                    if (w_ovf) begin
                        r_result <= {r_sign, EXP_MAX, {MAN_W{1'b0}}};
                        r_ovf    <= 1'b1;
                        r_unf    <= 1'b0;
                    end else if (w_unf) begin
                        r_result <= 32'd0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b1;
                    end else if (r_mant[MANT_W]) begin
                        r_mant <= r_mant >> 1;
                        r_exp  <= r_exp + 10'sd1;
                    end else if (!r_mant[MANT_W-1]) begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 10'sd1;
                    end else begin
                        r_result <= {r_sign, r_exp[EXP_W-1:0], r_mant[MAN_W-1:0]};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
